// File: rtl/subleq_pkg.sv
// Shared definitions for the SUBLEQ sequencer and its datapath: state
// encoding, state width and the decoded control vector.
package subleq_pkg;

    localparam int STATE_W = 4;

    // state       | meaning
    // FETCH_A     | address operand A
    // LOAD_A      | latch operand A
    // FETCH_B     | address operand B
    // LOAD_B      | latch operand B
    // FETCH_C     | address branch target C
    // LOAD_C      | latch branch target C
    // FETCH_MEM_A | address mem[A]
    // LOAD_MEM_A  | latch mem[A]
    // FETCH_MEM_B | address mem[B]
    // LOAD_MEM_B  | latch mem[B]
    // EXECUTE     | compute mem[B]-mem[A], capture flags
    // WRITEBACK   | store result to mem[B]
    // UPDATE_PC   | branch to C or fall through
    // HALT        | stopped until reset
    // IDLE        | waiting for run/step
    // (code 15)   | illegal, recovers to HALT
    typedef enum logic [STATE_W-1:0] {
        FETCH_A     = 4'd0,
        LOAD_A      = 4'd1,
        FETCH_B     = 4'd2,
        LOAD_B      = 4'd3,
        FETCH_C     = 4'd4,
        LOAD_C      = 4'd5,
        FETCH_MEM_A = 4'd6,
        LOAD_MEM_A  = 4'd7,
        FETCH_MEM_B = 4'd8,
        LOAD_MEM_B  = 4'd9,
        EXECUTE     = 4'd10,
        WRITEBACK   = 4'd11,
        UPDATE_PC   = 4'd12,
        HALT        = 4'd13,
        IDLE        = 4'd14
    } state_t;

    // wb is the raw writeback decode; the top qualifies it into mem_write.
    typedef struct packed {
        logic a_ld;
        logic b_ld;
        logic c_ld;
        logic mem_a_ld;
        logic mem_b_ld;
        logic result_ld;
        logic mem_read;
        logic wb;
        logic pc_ld;
        logic busy;
        logic halted;
    } ctrl_t;

endpackage

// File: rtl/subleq_ctrl_decode.sv
// Moore decode of the sequencer state into datapath controls and status.
module subleq_ctrl_decode
    import subleq_pkg::*;
(
    input  state_t state,
    output ctrl_t  ctrl
);

    // Pure state-to-control mapping; every field defaults low.
    always_comb begin
        ctrl = '0;
        case (state)
            LOAD_A:     ctrl.a_ld      = 1'b1;
            LOAD_B:     ctrl.b_ld      = 1'b1;
            LOAD_C:     ctrl.c_ld      = 1'b1;
            LOAD_MEM_A: ctrl.mem_a_ld  = 1'b1;
            LOAD_MEM_B: ctrl.mem_b_ld  = 1'b1;
            EXECUTE:    ctrl.result_ld = 1'b1;
            WRITEBACK:  ctrl.wb        = 1'b1;
            UPDATE_PC:  ctrl.pc_ld     = 1'b1;
            default:    ;
        endcase
        ctrl.mem_read = (state <= LOAD_MEM_B);
        ctrl.busy     = (state <= UPDATE_PC);
        ctrl.halted   = (state == HALT);
    end

endmodule

// File: rtl/subleq_sequencer.sv
// Control sequencer for a SUBLEQ core: 13-state instruction walk, run/step/
// halt handling, branch flag capture and retired-instruction counting.
module subleq_sequencer
    import subleq_pkg::*;
#(
    parameter int unsigned MAX_INSTR = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clk_enable,
    input  logic                run,
    input  logic                step,
    input  logic                halt_req,
    input  logic                zero,
    input  logic                negative,
    output logic                a_ld,
    output logic                b_ld,
    output logic                c_ld,
    output logic                mem_a_ld,
    output logic                mem_b_ld,
    output logic                result_ld,
    output logic                mem_read,
    output logic                mem_write,
    output logic                pc_ld,
    output logic [STATE_W-1:0]  state,
    output logic                busy,
    output logic                halted,
    output logic                branch_taken,
    output logic [31:0]         instr_count
);

    state_t      state_q;
    state_t      state_d;
    ctrl_t       ctrl;
    logic        halt_pend;
    logic        branch_q;
    logic [31:0] count_q;
    logic [31:0] count_inc;
    logic        max_hit;

    // Saturating increment; the limit check uses the post-increment value.
    always_comb begin
        count_inc = (&count_q) ? count_q : count_q + 32'd1;
        max_hit   = (MAX_INSTR != 0) && (count_inc == MAX_INSTR);
    end

    // Next-state logic; halt requests are only honoured at instruction boundaries.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH_A, LOAD_A, FETCH_B, LOAD_B, FETCH_C, LOAD_C,
            FETCH_MEM_A, LOAD_MEM_A, FETCH_MEM_B, LOAD_MEM_B,
            EXECUTE, WRITEBACK:
                state_d = state_t'(state_q + 4'd1);
            UPDATE_PC: begin
                if (halt_pend || max_hit) state_d = HALT;
                else if (run)             state_d = FETCH_A;
                else                      state_d = IDLE;
            end
            IDLE: begin
                if (halt_pend)        state_d = HALT;
                else if (run || step) state_d = FETCH_A;
                else                  state_d = IDLE;
            end
            HALT:    state_d = HALT;
            default: state_d = HALT;
        endcase
    end

    // State register, advancing only on enabled edges.
    always_ff @(posedge clk) begin
        if (!rst)            state_q <= IDLE;
        else if (clk_enable) state_q <= state_d;
    end

    // Sticky halt request; captured on every edge so a stalled pipe still sees it.
    always_ff @(posedge clk) begin
        if (!rst)          halt_pend <= 1'b0;
        else if (halt_req) halt_pend <= 1'b1;
    end

    // Branch flag captured from the ALU at EXECUTE and held until the next one.
    always_ff @(posedge clk) begin
        if (!rst)                                    branch_q <= 1'b0;
        else if (clk_enable && state_q == EXECUTE)   branch_q <= zero | negative;
    end

    // Retired-instruction counter, bumped as UPDATE_PC is left.
    always_ff @(posedge clk) begin
        if (!rst)                                    count_q <= '0;
        else if (clk_enable && state_q == UPDATE_PC) count_q <= count_inc;
    end

    subleq_ctrl_decode u_decode (
        .state (state_q),
        .ctrl  (ctrl)
    );

    // The write strobe is cut by reset so an aborted instruction never stores.
    assign mem_write    = ctrl.wb & clk_enable & rst;
    assign a_ld         = ctrl.a_ld;
    assign b_ld         = ctrl.b_ld;
    assign c_ld         = ctrl.c_ld;
    assign mem_a_ld     = ctrl.mem_a_ld;
    assign mem_b_ld     = ctrl.mem_b_ld;
    assign result_ld    = ctrl.result_ld;
    assign mem_read     = ctrl.mem_read;
    assign pc_ld        = ctrl.pc_ld;
    assign busy         = ctrl.busy;
    assign halted       = ctrl.halted;
    assign state        = state_q;
    assign branch_taken = branch_q;
    assign instr_count  = count_q;

endmodule
